// File: rtl/pwm_reader_8ch_50hz.sv
// Eight-channel 50 Hz PWM capture: per-channel high-time measurement in microseconds,
// loss-of-signal detection and an AXI4-Lite register file (WIDTHn, STATUS, CTRL).

module pwm_reader_8ch_50hz_lane #(
    parameter int TIMEOUT_US = 25_000
) (
    input  logic        gclk_i,
    input  logic        grst_i,
    input  logic        pin_i,
    input  logic        us_tick_i,
    input  logic        enable_i,
    input  logic        rd_clr_i,
    output logic [15:0] width_o,
    output logic        present_o,
    output logic        new_o
);
    localparam int TW = $clog2(TIMEOUT_US + 1);

    typedef enum logic {IDLE, HIGH} state_t;

    state_t        state_q;
    logic [2:0]    pipe_q;
    logic          rise_q, fall_q;
    logic [15:0]   hi_cnt_q;
    logic [TW-1:0] to_cnt_q;
    logic          lost;

    assign lost = (to_cnt_q == TW'(TIMEOUT_US));

    // Chain resets high so a pin already high after reset is not taken as a rising edge.
    always_ff @(posedge gclk_i) begin
        if (grst_i) begin
            pipe_q <= 3'b111;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            pipe_q <= {pipe_q[1:0], pin_i};
            rise_q <= pipe_q[1] & ~pipe_q[2];
            fall_q <= ~pipe_q[1] & pipe_q[2];
        end
    end

    always_ff @(posedge gclk_i) begin
        if (grst_i) begin
            state_q   <= IDLE;
            hi_cnt_q  <= '0;
            to_cnt_q  <= '0;
            width_o   <= '0;
            present_o <= 1'b0;
            new_o     <= 1'b0;
        end else if (!enable_i) begin
            state_q   <= IDLE;
            hi_cnt_q  <= '0;
            to_cnt_q  <= '0;
            present_o <= 1'b0;
            new_o     <= 1'b0;
        end else begin
            if (us_tick_i && !lost)
                to_cnt_q <= to_cnt_q + 1'b1;
            if (state_q == HIGH && us_tick_i && hi_cnt_q != 16'hFFFF)
                hi_cnt_q <= hi_cnt_q + 1'b1;
            if (rd_clr_i)
                new_o <= 1'b0;
            // Capture is ordered after the read clear so a same-cycle capture keeps NEW set.
            if (state_q == IDLE && rise_q) begin
                state_q  <= HIGH;
                hi_cnt_q <= '0;
                to_cnt_q <= '0;
            end else if (state_q == HIGH && fall_q) begin
                state_q   <= IDLE;
                width_o   <= hi_cnt_q;
                new_o     <= 1'b1;
                present_o <= 1'b1;
            end else if (lost) begin
                state_q   <= IDLE;
                present_o <= 1'b0;
            end
        end
    end
endmodule

module pwm_reader_8ch_50hz #(
    parameter int CLK_FREQ_HZ        = 100_000_000,
    parameter int TIMEOUT_US         = 25_000,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            gclk_i,
    input  logic                            grst_i,
    input  logic [7:0]                      pwm_in_i,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr_i,
    input  logic [2:0]                      s_axi_awprot_i,
    input  logic                            s_axi_awvalid_i,
    output logic                            s_axi_awready_o,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata_i,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb_i,
    input  logic                            s_axi_wvalid_i,
    output logic                            s_axi_wready_o,
    output logic [1:0]                      s_axi_bresp_o,
    output logic                            s_axi_bvalid_o,
    input  logic                            s_axi_bready_i,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr_i,
    input  logic [2:0]                      s_axi_arprot_i,
    input  logic                            s_axi_arvalid_i,
    output logic                            s_axi_arready_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata_o,
    output logic [1:0]                      s_axi_rresp_o,
    output logic                            s_axi_rvalid_o,
    input  logic                            s_axi_rready_i
);
    localparam int NUM_LANES = 8;
    localparam int DIV       = CLK_FREQ_HZ / 1_000_000;
    localparam int PW        = $clog2(DIV);
    localparam int IW        = C_S_AXI_ADDR_WIDTH - 2;

    logic [PW-1:0]                  pre_q;
    logic                           tick_q;
    logic [7:0]                     ctrl_q;
    logic                           wr_rdy_q, ar_rdy_q, wr_hs, ar_hs;
    logic [IW-1:0]                  aw_idx, ar_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]  rdata_d;
    logic [NUM_LANES-1:0]           rd_clr, present_v, new_v;
    logic [NUM_LANES-1:0][15:0]     width_v;
    logic                           unused_sig;

    assign unused_sig = ^{s_axi_awprot_i, s_axi_arprot_i, s_axi_awaddr_i[1:0],
                          s_axi_araddr_i[1:0], s_axi_wdata_i[C_S_AXI_DATA_WIDTH-1:8],
                          s_axi_wstrb_i[C_S_AXI_DATA_WIDTH/8-1:1]};

    always_ff @(posedge gclk_i) begin
        if (grst_i) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= (pre_q == PW'(DIV - 1)) ? '0 : pre_q + 1'b1;
            tick_q <= (pre_q == PW'(DIV - 1));
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign rd_clr[g] = ar_hs && (ar_idx == IW'(g));
        pwm_reader_8ch_50hz_lane #(.TIMEOUT_US(TIMEOUT_US)) u_lane (
            .gclk_i    (gclk_i),
            .grst_i    (grst_i),
            .pin_i     (pwm_in_i[g]),
            .us_tick_i (tick_q),
            .enable_i  (ctrl_q[g]),
            .rd_clr_i  (rd_clr[g]),
            .width_o   (width_v[g]),
            .present_o (present_v[g]),
            .new_o     (new_v[g])
        );
    end

    assign aw_idx = s_axi_awaddr_i[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_idx = s_axi_araddr_i[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_hs  = wr_rdy_q & s_axi_awvalid_i & s_axi_wvalid_i;
    assign ar_hs  = ar_rdy_q & s_axi_arvalid_i;

    always_comb begin
        rdata_d = '0;
        if (ar_idx < IW'(NUM_LANES))
            rdata_d = {16'b0, width_v[ar_idx[2:0]]};
        else if (ar_idx == IW'(8))
            rdata_d = {16'b0, new_v, present_v};
        else if (ar_idx == IW'(9))
            rdata_d = {24'b0, ctrl_q};
    end

    // Ready is a one-cycle pulse; the !ready term keeps it from re-firing on held valids.
    always_ff @(posedge gclk_i) begin
        if (grst_i) begin
            wr_rdy_q       <= 1'b0;
            s_axi_bvalid_o <= 1'b0;
            ctrl_q         <= 8'hFF;
            ar_rdy_q       <= 1'b0;
            s_axi_rvalid_o <= 1'b0;
            s_axi_rdata_o  <= '0;
        end else begin
            wr_rdy_q <= ~wr_rdy_q & s_axi_awvalid_i & s_axi_wvalid_i & ~s_axi_bvalid_o;
            if (wr_hs)
                s_axi_bvalid_o <= 1'b1;
            else if (s_axi_bready_i)
                s_axi_bvalid_o <= 1'b0;
            if (wr_hs && aw_idx == IW'(9) && s_axi_wstrb_i[0])
                ctrl_q <= s_axi_wdata_i[7:0];

            ar_rdy_q <= ~ar_rdy_q & s_axi_arvalid_i & ~s_axi_rvalid_o;
            if (ar_hs) begin
                s_axi_rvalid_o <= 1'b1;
                s_axi_rdata_o  <= rdata_d;
            end else if (s_axi_rready_i) begin
                s_axi_rvalid_o <= 1'b0;
            end
        end
    end

    assign s_axi_awready_o = wr_rdy_q;
    assign s_axi_wready_o  = wr_rdy_q;
    assign s_axi_arready_o = ar_rdy_q;
    assign s_axi_bresp_o   = 2'b00;
    assign s_axi_rresp_o   = 2'b00;
endmodule
